// File: rtl/render_pkg.sv
// render_pkg: framebuffer geometry defaults, command encoding, pixel word layout and painter FSM states
package render_pkg;
  localparam int H_RES_D = 800;
  localparam int V_RES_D = 600;
  localparam int TILE_D = 16;
  localparam int WR_GAP_D = 2;
  localparam logic CMD_TILE = 1'b0;
  localparam logic CMD_CLEAR = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_TILE, ST_CLEAR} state_t;
  function automatic logic [31:0] pix_word(input logic [23:0] color);
    return {8'h00, color};
  endfunction
endpackage

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: paced write strobe and incremental tile/clear address walk (i_start/i_clear/i_base in; o_wr_en/o_addr/o_last out)
module tile_addr_gen
  import render_pkg::*;
#(
  parameter int H_RES = H_RES_D,
  parameter int V_RES = V_RES_D,
  parameter int TILE = TILE_D,
  parameter int WR_GAP = WR_GAP_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_clear,
  input  logic [19:0] i_base,
  output logic        o_wr_en,
  output logic [19:0] o_addr,
  output logic        o_last
);
  localparam int CW = $clog2(TILE);
  localparam logic [CW-1:0] C_END = CW'(TILE - 1);
  localparam logic [19:0] A_END = 20'(H_RES * V_RES - 1);
  localparam logic [19:0] ROW_STEP = 20'(H_RES - (TILE - 1));
  logic          r_clear;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [7:0]    r_gap;
  assign o_last = r_clear ? o_addr == A_END : r_col == C_END && r_row == C_END;
  always_ff @(posedge clk)
    if (!rst_n) begin
      o_wr_en <= 1'b0;
      o_addr  <= '0;
      r_clear <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_gap   <= '0;
    end else if (i_start) begin
      o_wr_en <= 1'b1;
      o_addr  <= i_base;
      r_clear <= i_clear;
      r_col   <= '0;
      r_row   <= '0;
      r_gap   <= '0;
    end else if (o_wr_en) begin
      o_wr_en <= !o_last && WR_GAP == 0;
      r_gap   <= o_last ? 8'd0 : 8'(WR_GAP);
      o_addr  <= o_last ? o_addr : (r_clear || r_col != C_END) ? o_addr + 20'd1 : o_addr + ROW_STEP;
      r_col   <= r_col + 1'b1;
      r_row   <= r_col == C_END ? r_row + 1'b1 : r_row;
    end else if (r_gap != 8'd0) begin
      o_wr_en <= r_gap == 8'd1;
      r_gap   <= r_gap - 8'd1;
    end
endmodule

// File: rtl/tile_painter.sv
// tile_painter: command FSM painting a tile or clearing the framebuffer via paced SRAM writes (req_* handshake in; sram_wr_*, done, err out)
module tile_painter
  import render_pkg::*;
#(
  parameter int H_RES = H_RES_D,
  parameter int V_RES = V_RES_D,
  parameter int TILE = TILE_D,
  parameter int WR_GAP = WR_GAP_D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_cmd,
  input  logic [5:0]  req_tx,
  input  logic [5:0]  req_ty,
  input  logic [23:0] req_color,
  output logic        sram_wr_en,
  output logic [19:0] sram_wr_addr,
  output logic [31:0] sram_wr_data,
  output logic        done,
  output logic        err
);
  localparam logic [6:0] TX_N = 7'(H_RES / TILE);
  localparam logic [6:0] TY_N = 7'(V_RES / TILE);
  state_t      r_state;
  logic [23:0] r_color;
  logic        w_accept;
  logic        w_tile_ok;
  logic        w_start;
  logic        w_last;
  logic [19:0] w_base;
  assign req_ready = r_state == ST_IDLE;
  assign w_accept = req_valid && req_ready;
  assign w_tile_ok = {1'b0, req_tx} < TX_N && {1'b0, req_ty} < TY_N;
  assign w_start = w_accept && (req_cmd == CMD_CLEAR || w_tile_ok);
  assign w_base = req_cmd == CMD_CLEAR ? 20'd0 : 20'(req_ty) * 20'(TILE * H_RES) + 20'(req_tx) * 20'(TILE);
  assign sram_wr_data = pix_word(r_color);
  tile_addr_gen #(
    .H_RES(H_RES),
    .V_RES(V_RES),
    .TILE(TILE),
    .WR_GAP(WR_GAP)
  ) u_gen (
    .clk(clk),
    .rst_n(rst_n),
    .i_start(w_start),
    .i_clear(req_cmd == CMD_CLEAR),
    .i_base(w_base),
    .o_wr_en(sram_wr_en),
    .o_addr(sram_wr_addr),
    .o_last(w_last)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_color <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= sram_wr_en && w_last;
      err  <= w_accept && req_cmd == CMD_TILE && !w_tile_ok;
      if (w_start) begin
        r_state <= req_cmd == CMD_CLEAR ? ST_CLEAR : ST_TILE;
        r_color <= req_color;
      end else if (sram_wr_en && w_last) r_state <= ST_IDLE;
    end
endmodule

// File: tb/tb_tile_painter.sv
// tb_tile_painter: randomized scoreboard bench with a cycle-timed write/done/err reference model
module tb_tile_painter;
  localparam int H = 64;
  localparam int V = 48;
  localparam int T = 16;
  localparam int G = 2;
  localparam int TXN = H / T;
  localparam int TYN = V / T;
  typedef struct {int cyc; int addr; logic [31:0] data;} wr_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_cmd = 1'b0;
  logic [5:0]  req_tx = '0;
  logic [5:0]  req_ty = '0;
  logic [23:0] req_color = '0;
  logic        sram_wr_en;
  logic [19:0] sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        done;
  logic        err;
  wr_t wq[$];
  int  dq[$];
  int  eq[$];
  wr_t mon_e;
  int  mon_c;
  int  cyc = 0;
  int  free = 0;
  int  checks = 0;
  int  errors = 0;
  int  s;
  tile_painter #(.H_RES(H), .V_RES(V), .TILE(T), .WR_GAP(G)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_tx(req_tx),
    .req_ty(req_ty),
    .req_color(req_color),
    .sram_wr_en(sram_wr_en),
    .sram_wr_addr(sram_wr_addr),
    .sram_wr_data(sram_wr_data),
    .done(done),
    .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, got, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (sram_wr_en !== 1'b0) begin
      chk("write_expected", 64'(wq.size() != 0), 1);
      if (wq.size() != 0) begin
        mon_e = wq.pop_front();
        chk("wr_addr", 64'(sram_wr_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(sram_wr_data), 64'(mon_e.data));
        chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
    if (done !== 1'b0) begin
      chk("done_expected", 64'(dq.size() != 0), 1);
      if (dq.size() != 0) begin
        mon_c = dq.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_c));
      end
    end
    if (err !== 1'b0) begin
      chk("err_expected", 64'(eq.size() != 0), 1);
      if (eq.size() != 0) begin
        mon_c = eq.pop_front();
        chk("err_cycle", 64'(cyc), 64'(mon_c));
      end
    end
  end
  task automatic issue(input logic cmd, input int tx, input int ty, input logic [23:0] col);
    int a;
    int n;
    @(negedge clk);
    req_cmd = cmd;
    req_tx = 6'(tx);
    req_ty = 6'(ty);
    req_color = col;
    req_valid = 1'b1;
    a = cyc > free ? cyc : free;
    while (cyc < a) begin
      chk("ready_busy", 64'(req_ready), 0);
      @(negedge clk);
    end
    chk("ready_idle", 64'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_cmd = 1'($urandom);
    req_tx = 6'($urandom);
    req_ty = 6'($urandom);
    req_color = 24'($urandom);
    n = cmd ? H * V : (tx < TXN && ty < TYN) ? T * T : 0;
    if (n == 0) begin
      eq.push_back(a + 1);
      free = a + 1;
    end else begin
      for (int k = 0; k < n; k++)
        wq.push_back('{a + 1 + k * (G + 1), cmd ? k : (ty * T + k / T) * H + tx * T + k % T, {8'h00, col}});
      free = a + 1 + (n - 1) * (G + 1) + 1;
      dq.push_back(free);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 1);
    chk("rst_wr_en", 64'(sram_wr_en), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    rst_n = 1'b1;
    free = cyc;
    issue(1'b0, 0, 0, 24'hFF0000);
    issue(1'b0, TXN - 1, TYN - 1, 24'hA5A5A5);
    issue(1'b0, TXN, 0, 24'h111111);
    issue(1'b0, 0, TYN, 24'h222222);
    issue(1'b0, 63, 63, 24'h333333);
    issue(1'b0, 1, 1, 24'h0000FF);
    issue(1'b0, 2, 0, 24'h00FF00);
    repeat (12) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(1'b0, $urandom_range(0, TXN + 1), $urandom_range(0, TYN + 1), 24'($urandom));
    end
    issue(1'b1, 0, 0, 24'h123456);
    issue(1'b1, 5, 5, 24'h0F0F0F);
    s = cyc + 99 * (G + 1);
    while (cyc < s) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    dq.delete();
    chk("abort_wr_en", 64'(sram_wr_en), 0);
    chk("abort_ready", 64'(req_ready), 1);
    chk("abort_done", 64'(done), 0);
    free = cyc;
    repeat (5) begin
      @(negedge clk);
      chk("abort_quiet", 64'({sram_wr_en, done, err}), 0);
    end
    issue(1'b0, 1, 2, 24'h00FF00);
    while (cyc < free + 5) @(negedge clk);
    chk("writes_left", 64'(wq.size()), 0);
    chk("dones_left", 64'(dq.size()), 0);
    chk("errs_left", 64'(eq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tile_painter.md
TILE_PAINTER -- requirements
Module: tile_painter

Interface
REQ-001 Parameter: H_RES, 800, framebuffer width in pixels (SRAM words per row).
REQ-002 Parameter: V_RES, 600, framebuffer height in pixels.
REQ-003 Parameter: TILE, 16, tile edge in pixels; power of two.
REQ-004 Parameter: WR_GAP, 2, idle cycles enforced between consecutive SRAM writes.
REQ-005 Port: clk  input  1  single clock; all logic rising-edge.
REQ-006 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port: req_valid  input  1  command offered.
REQ-008 Port: req_ready  output  1  command accepted when high with req_valid.
REQ-009 Port: req_cmd  input  1  0 = paint tile, 1 = clear whole screen.
REQ-010 Port: req_tx  input  6  tile column (tile cmd only).
REQ-011 Port: req_ty  input  6  tile row (tile cmd only).
REQ-012 Port: req_color  input  24  fill colour {R,G,B}.
REQ-013 Port: sram_wr_en  output  1  one-cycle write strobe to the SRAM controller.
REQ-014 Port: sram_wr_addr  output  20  pixel word address.
REQ-015 Port: sram_wr_data  output  32  pixel word.
REQ-016 Port: done  output  1  one-cycle pulse at command completion.
REQ-017 Port: err  output  1  one-cycle pulse on rejected tile command.

Function
REQ-018 States: IDLE, TILE, CLEAR; req_ready SHALL be high only in IDLE.
REQ-019 Handshake: command captured on the cycle req_valid && req_ready; command fields latched, later input changes ignored.
REQ-020 Tile command valid iff req_tx < H_RES/TILE (50) and req_ty < V_RES/TILE (37); otherwise err pulses the next cycle, no writes, done not pulsed, stay IDLE.
REQ-021 Valid tile: IDLE->TILE; base = req_ty*TILE*H_RES + req_tx*TILE, computed at acceptance.
REQ-022 TILE order: row-major, col 0..TILE-1 within row, rows 0..TILE-1; address = base + row*H_RES + col, produced by incremental add (+1, then +H_RES-(TILE-1) at row end), no per-pixel multiply.
REQ-023 CLEAR: addresses 0 .. H_RES*V_RES-1 ascending (0..479999 at defaults).
REQ-024 First sram_wr_en asserts the cycle after acceptance; consecutive strobes separated by exactly WR_GAP low cycles; sram_wr_en never high two cycles running when WR_GAP>0.
REQ-025 sram_wr_data = {8'h00, colour}; addr/data valid only while sram_wr_en high, don't-care otherwise.
REQ-026 done pulses the cycle after the last write's strobe; state returns to IDLE that same cycle, req_ready high with it.
REQ-027 Exactly TILE*TILE writes per tile command, H_RES*V_RES per clear; no duplicate or skipped addresses.
REQ-028 Address arithmetic 20-bit unsigned; max address 479999 never exceeded; no wrap.

Reset
REQ-029 rst_n low at a clock edge: next cycle state IDLE, req_ready 1, sram_wr_en 0, done 0, err 0, address/counters 0.
REQ-030 Reset mid-command aborts it: no further writes, no done pulse; partial framebuffer contents left as written.

Structure
REQ-031 Shared package render_pkg holds H_RES, V_RES, TILE defaults, command encoding (CMD_TILE=0, CMD_CLEAR=1), pixel-word layout, state enum.
REQ-032 One sub-module, tile_addr_gen: counters, gap timer, incremental address; tile_painter holds FSM, handshake, range check.

Verification
REQ-033 Tile (0,0), colour 0xFF0000, WR_GAP=0 -> 256 strobes on consecutive cycles, addrs 0..15, 800..815, ..., 12000..12015, data 0x00FF0000, done one cycle after addr 12015.
REQ-034 Tile (49,36), WR_GAP=2 -> first addr 461584, last 473599, strobes every 3 cycles, 256 total, done once.
REQ-035 Tile (50,0) and tile (0,37) -> err pulse each, zero strobes, no done, req_ready high again next cycle.
REQ-036 Clear colour 0x123456 -> 480000 strobes, addrs 0..479999 in order, data 0x00123456, single done.
REQ-037 req_valid held high with new tile during running tile -> req_ready low, second command accepted only the cycle done pulses, its first strobe the following cycle.
REQ-038 rst_n low for 1 cycle after 100 writes of a clear -> sram_wr_en 0 from next cycle, no done, req_ready 1; following tile command runs normally.
